// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager endpoint backed by a flop scratchpad.
// Single-beat requests, one response register, D valid the cycle after A is accepted.
module tl_ul_sram_responder #(
    parameter logic [35:0] BASE_ADDR = 36'h0_1F00_0000,
    parameter int          DEPTH     = 64,
    parameter int          SRC_W     = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic             auto_in_a_ready,
    input  logic             auto_in_a_valid,
    input  logic [2:0]       auto_in_a_bits_opcode,
    input  logic [2:0]       auto_in_a_bits_size,
    input  logic [SRC_W-1:0] auto_in_a_bits_source,
    input  logic [35:0]      auto_in_a_bits_address,
    input  logic [7:0]       auto_in_a_bits_mask,
    input  logic [63:0]      auto_in_a_bits_data,
    input  logic             auto_in_d_ready,
    output logic             auto_in_d_valid,
    output logic [2:0]       auto_in_d_bits_opcode,
    output logic [2:0]       auto_in_d_bits_size,
    output logic [SRC_W-1:0] auto_in_d_bits_source,
    output logic             auto_in_d_bits_denied,
    output logic [63:0]      auto_in_d_bits_data
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [35:0] SPAN  = 36'(DEPTH * 8);

    logic [63:0]      mem_q [DEPTH];
    logic             dValid_q, dValid_d;
    logic [2:0]       dOpcode_q, dOpcode_d;
    logic [2:0]       dSize_q, dSize_d;
    logic [SRC_W-1:0] dSource_q, dSource_d;
    logic             dDenied_q, dDenied_d;
    logic [63:0]      dData_q, dData_d;

    logic             aFire, dFire;
    logic             isGet, isPut, opOk, alignOk, denied;
    logic [35:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [63:0]      wordRd, wordWr;

    assign auto_in_a_ready = ~dValid_q | auto_in_d_ready;
    assign aFire           = auto_in_a_valid & auto_in_a_ready;
    assign dFire           = dValid_q & auto_in_d_ready;

    // Addresses below the base wrap to a huge offset and fall out of range.
    assign offset = auto_in_a_bits_address - BASE_ADDR;
    assign idx    = offset[IDX_W+2:3];
    assign wordRd = mem_q[idx];

    assign isGet = (auto_in_a_bits_opcode == 3'd4);
    assign isPut = (auto_in_a_bits_opcode == 3'd0) | (auto_in_a_bits_opcode == 3'd1);
    assign opOk  = isGet | isPut;

    always_comb begin
        alignOk = 1'b0;
        case (auto_in_a_bits_size)
            3'd0:    alignOk = 1'b1;
            3'd1:    alignOk = (auto_in_a_bits_address[0] == 1'b0);
            3'd2:    alignOk = (auto_in_a_bits_address[1:0] == 2'b00);
            3'd3:    alignOk = (auto_in_a_bits_address[2:0] == 3'b000);
            default: alignOk = 1'b0;
        endcase
    end

    assign denied = (offset >= SPAN) | ~alignOk | ~opOk;

    always_comb begin
        wordWr = wordRd;
        for (int b = 0; b < 8; b++) begin
            if (auto_in_a_bits_mask[b]) begin
                wordWr[8*b +: 8] = auto_in_a_bits_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (aFire && isPut && !denied) begin
            mem_q[idx] <= wordWr;
        end
    end

    // A new accept reloads the response register even when the old one drains this cycle.
    always_comb begin
        dValid_d  = dValid_q;
        dOpcode_d = dOpcode_q;
        dSize_d   = dSize_q;
        dSource_d = dSource_q;
        dDenied_d = dDenied_q;
        dData_d   = dData_q;
        if (aFire) begin
            dValid_d  = 1'b1;
            dOpcode_d = isGet ? 3'd1 : 3'd0;
            dSize_d   = auto_in_a_bits_size;
            dSource_d = auto_in_a_bits_source;
            dDenied_d = denied;
            dData_d   = (isGet && !denied) ? wordRd : 64'd0;
        end else if (dFire) begin
            dValid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dValid_q  <= 1'b0;
            dOpcode_q <= 3'd0;
            dSize_q   <= 3'd0;
            dSource_q <= '0;
            dDenied_q <= 1'b0;
            dData_q   <= 64'd0;
        end else begin
            dValid_q  <= dValid_d;
            dOpcode_q <= dOpcode_d;
            dSize_q   <= dSize_d;
            dSource_q <= dSource_d;
            dDenied_q <= dDenied_d;
            dData_q   <= dData_d;
        end
    end

    assign auto_in_d_valid       = dValid_q;
    assign auto_in_d_bits_opcode = dOpcode_q;
    assign auto_in_d_bits_size   = dSize_q;
    assign auto_in_d_bits_source = dSource_q;
    assign auto_in_d_bits_denied = dDenied_q;
    assign auto_in_d_bits_data   = dData_q;

endmodule
